// File: rtl/register_writeback_queue.sv
// Register write-back queue: buffers {dest, data} writes and issues one per cycle to the register file.
// Define WB_FORWARD_EN to build the youngest-match forwarding data path on a/b_fwd_data.
module register_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [3:0]                 wr_dest,
  input  logic [31:0]                wr_data,
  input  logic                       drain_hold,
  output logic [31:0]                data_in,
  output logic [3:0]                 decoder_control,
  output logic                       load_enable,
  input  logic [3:0]                 a_select,
  input  logic [3:0]                 b_select,
  output logic                       a_pending,
  output logic                       b_pending,
  output logic [31:0]                a_fwd_data,
  output logic [31:0]                b_fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    dest_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          accept;
  logic          pop;
  logic          not_empty;

  assign not_empty       = (count_q != '0);
  // wr_ready looks only at the registered count, so a pop never frees a slot in its own cycle
  assign wr_ready        = (count_q < (AW+1)'(DEPTH));
  assign accept          = wr_valid && wr_ready;
  assign load_enable     = not_empty && !drain_hold && !reset;
  assign pop             = load_enable;
  assign data_in         = not_empty ? data_q[head_q] : 32'd0;
  assign decoder_control = not_empty ? dest_q[head_q] : 4'd0;
  assign count           = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (accept) tail_d = tail_q + 1'b1;
    if (pop)    head_d = head_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is defined solely by head/count
  always_ff @(posedge clk) begin
    if (accept) begin
      dest_q[tail_q] <= wr_dest;
      data_q[tail_q] <= wr_data;
    end
  end

  logic [31:0] a_match_data, b_match_data;

  // Walk oldest to youngest so the last hit is the youngest matching entry
  always_comb begin
    logic [AW-1:0] idx;
    a_pending    = 1'b0;
    b_pending    = 1'b0;
    a_match_data = 32'd0;
    b_match_data = 32'd0;
    idx          = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if ((AW+1)'(k) < count_q) begin
        if (dest_q[idx] == a_select) begin
          a_pending    = 1'b1;
          a_match_data = data_q[idx];
        end
        if (dest_q[idx] == b_select) begin
          b_pending    = 1'b1;
          b_match_data = data_q[idx];
        end
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign a_fwd_data = a_match_data;
  assign b_fwd_data = b_match_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{a_match_data, b_match_data};
  assign a_fwd_data = 32'd0;
  assign b_fwd_data = 32'd0;
`endif

endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed self-checking bench for register_writeback_queue (DEPTH=4).
module tb_register_writeback_queue;

  logic        clk = 1'b0;
  logic        reset, wr_valid, wr_ready, drain_hold, load_enable;
  logic [3:0]  wr_dest, decoder_control, a_select, b_select;
  logic [31:0] wr_data, data_in, a_fwd_data, b_fwd_data;
  logic        a_pending, b_pending;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  register_writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_dest(wr_dest), .wr_data(wr_data), .drain_hold(drain_hold),
    .data_in(data_in), .decoder_control(decoder_control), .load_enable(load_enable),
    .a_select(a_select), .b_select(b_select), .a_pending(a_pending), .b_pending(b_pending),
    .a_fwd_data(a_fwd_data), .b_fwd_data(b_fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] d, input logic [31:0] v);
    wr_valid = 1'b1;
    wr_dest  = d;
    wr_data  = v;
  endtask

  logic [31:0] exp_fwd;

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_dest = '0; wr_data = '0;
    drain_hold = 1'b0; a_select = 4'd0; b_select = 4'd0;
`ifdef WB_FORWARD_EN
    exp_fwd = 32'h22;
`else
    exp_fwd = 32'h0;
`endif
    tick(); tick();
    check("le_in_reset", {31'd0, load_enable}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_a_pending", {31'd0, a_pending}, 32'd0);
    check("rst_b_pending", {31'd0, b_pending}, 32'd0);
    check("rst_a_fwd", a_fwd_data, 32'd0);
    check("rst_b_fwd", b_fwd_data, 32'd0);
    check("rst_data_in", data_in, 32'd0);
    check("rst_dec", {28'd0, decoder_control}, 32'd0);
    check("rst_le", {31'd0, load_enable}, 32'd0);

    // Single write, one-cycle latency
    offer(4'd5, 32'hDEADBEEF);
    tick();
    wr_valid = 1'b0;
    #1;
    check("single_le", {31'd0, load_enable}, 32'd1);
    check("single_dec", {28'd0, decoder_control}, 32'd5);
    check("single_data", data_in, 32'hDEADBEEF);
    check("single_count1", {29'd0, count}, 32'd1);
    tick();
    check("single_count0", {29'd0, count}, 32'd0);
    check("single_le_off", {31'd0, load_enable}, 32'd0);

    // Fill to full under hold, fifth offer refused
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(4'(i + 1), 32'hA0 + i);
      tick();
    end
    check("full_count", {29'd0, count}, 32'd4);
    check("full_ready", {31'd0, wr_ready}, 32'd0);
    check("full_hold_le", {31'd0, load_enable}, 32'd0);
    offer(4'd9, 32'hFF);
    tick();
    wr_valid = 1'b0;
    check("fifth_refused", {29'd0, count}, 32'd4);
    a_select = 4'd3; b_select = 4'd9;
    #1;
    check("full_a_pend", {31'd0, a_pending}, 32'd1);
    check("full_b_pend", {31'd0, b_pending}, 32'd0);
    drain_hold = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_le", {31'd0, load_enable}, 32'd1);
      check("drain_dec", {28'd0, decoder_control}, 32'(i + 1));
      check("drain_data", data_in, 32'hA0 + i);
      if (i == 0) check("full_pop_ready", {31'd0, wr_ready}, 32'd0);
      tick();
    end
    check("drain_empty", {29'd0, count}, 32'd0);
    check("drain_le_off", {31'd0, load_enable}, 32'd0);

    // Forwarding: youngest of duplicates; in-flight accept not visible
    drain_hold = 1'b1;
    a_select = 4'd3; b_select = 4'd4;
    offer(4'd3, 32'h11);
    #1;
    check("inflight_not_pend", {31'd0, a_pending}, 32'd0);
    tick();
    offer(4'd3, 32'h22);
    tick();
    wr_valid = 1'b0;
    #1;
    check("fwd_a_pend", {31'd0, a_pending}, 32'd1);
    check("fwd_a_data", a_fwd_data, exp_fwd);
    check("fwd_b_pend", {31'd0, b_pending}, 32'd0);
    check("fwd_b_data", b_fwd_data, 32'd0);
    drain_hold = 1'b0;
    #1;
    check("dup_first_dec", {28'd0, decoder_control}, 32'd3);
    check("dup_first_data", data_in, 32'h11);
    tick();
    check("dup_second_data", data_in, 32'h22);
    tick();
    check("dup_empty", {29'd0, count}, 32'd0);
    check("empty_a_pend", {31'd0, a_pending}, 32'd0);

    // Simultaneous accept and pop at count=2, wrapping past the last slot
    drain_hold = 1'b1;
    offer(4'd7, 32'h70); tick();
    offer(4'd8, 32'h80); tick();
    drain_hold = 1'b0;
    offer(4'd9, 32'h90);
    #1;
    check("sim_head0", data_in, 32'h70);
    tick();
    check("sim_count_a", {29'd0, count}, 32'd2);
    check("sim_head1", data_in, 32'h80);
    offer(4'd10, 32'hA0);
    tick();
    wr_valid = 1'b0;
    #1;
    check("sim_count_b", {29'd0, count}, 32'd2);
    check("sim_head2_dec", {28'd0, decoder_control}, 32'd9);
    check("sim_head2", data_in, 32'h90);
    tick();
    check("sim_head3", data_in, 32'hA0);
    check("sim_count_c", {29'd0, count}, 32'd1);
    tick();
    check("sim_empty", {29'd0, count}, 32'd0);

    // Reset mid-drain discards the queue
    drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(4'(12 + i), 32'hC0 + i);
      tick();
    end
    wr_valid = 1'b0;
    check("mid_count3", {29'd0, count}, 32'd3);
    drain_hold = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_reset_le", {31'd0, load_enable}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_after_count", {29'd0, count}, 32'd0);
    check("mid_after_ready", {31'd0, wr_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("mid_no_write", {31'd0, load_enable}, 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/register_writeback_queue.md
REGISTER_WRITEBACK_QUEUE -- requirements
Module: register_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of pending-write entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_valid  input  1  producer offers a register write this cycle.
REQ-005 SHALL have port wr_ready  output  1  queue can accept the offered write.
REQ-006 SHALL have port wr_dest  input  4  destination register number.
REQ-007 SHALL have port wr_data  input  32  value to write.
REQ-008 SHALL have port drain_hold  input  1  inhibits issuing a write to the register file.
REQ-009 SHALL have port data_in  output  32  write data to register file.
REQ-010 SHALL have port decoder_control  output  4  write register number to register file.
REQ-011 SHALL have port load_enable  output  1  register file write strobe.
REQ-012 SHALL have ports a_select, b_select  input  4 each  register numbers being read by the datapath.
REQ-013 SHALL have ports a_pending, b_pending  output  1 each  a queued write targets that register.
REQ-014 SHALL have ports a_fwd_data, b_fwd_data  output  32 each  youngest queued value for that register (see Configuration).
REQ-015 SHALL have port count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL store entries {dest, data} in a circular FIFO with head, tail pointers wrapping modulo DEPTH.
REQ-017 SHALL drive wr_ready = (count < DEPTH); accept occurs when wr_valid and wr_ready are both high at a clock edge.
REQ-018 SHALL present the head entry combinationally on data_in/decoder_control, with load_enable = (count != 0) and not drain_hold and not reset.
REQ-019 SHALL pop the head at the edge where load_enable is high (one register-file write per cycle max).
REQ-020 SHALL give minimum latency of one cycle: a write accepted at edge N drives load_enable throughout cycle N+1 when the queue was empty and drain_hold is low.
REQ-021 SHALL, on simultaneous accept and pop, update both pointers and leave count unchanged; when full, a pop in the same cycle does NOT raise wr_ready in that cycle.
REQ-022 SHALL drive data_in and decoder_control to 0 when count is 0.
REQ-023 SHALL drive a_pending high when any occupied entry has dest == a_select; likewise b_pending for b_select; the entry being accepted in the same cycle is not included.
REQ-024 SHALL, for multiple matches, select the youngest (closest to tail) entry for forwarding.
REQ-025 SHALL preserve FIFO order for repeated writes to the same register; all duplicates are written, oldest first.
REQ-026 SHALL never underflow: load_enable stays 0 when empty, and count never exceeds DEPTH.

Reset
REQ-027 SHALL, while reset is high at an edge, clear head, tail, count to 0, discarding all entries including any accepted or popped that cycle.
REQ-028 SHALL force load_enable = 0 during any cycle reset is high; after reset: wr_ready=1, count=0, a/b_pending=0, a/b_fwd_data=0, data_in=0, decoder_control=0.

Configuration
REQ-029 SHALL compile the forwarding data path only when macro WB_FORWARD_EN is defined: a/b_fwd_data carry the youngest matching entry's data, 0 when no match.
REQ-030 SHALL, without WB_FORWARD_EN, tie a_fwd_data and b_fwd_data to 0 while a/b_pending remain functional (datapath stalls on pending instead).

Verification
REQ-031 SHALL cover single write: reset, empty queue, accept dest=5 data=0xDEADBEEF -> next cycle load_enable=1, decoder_control=5, data_in=0xDEADBEEF; following cycle count=0.
REQ-032 SHALL cover fill/full: drain_hold=1, DEPTH=4 accepts -> count=4, wr_ready=0, fifth offer not accepted; release hold -> four writes in order over four cycles.
REQ-033 SHALL cover forwarding: queue dest=3 data=0x11 then dest=3 data=0x22 under hold, a_select=3 -> a_pending=1, a_fwd_data=0x22 (0 without WB_FORWARD_EN); b_select=4 -> b_pending=0.
REQ-034 SHALL cover simultaneous accept and pop with count=2 -> count stays 2, pointer wrap past DEPTH-1 keeps order intact.
REQ-035 SHALL cover reset mid-drain: 3 entries queued, reset for one cycle -> load_enable=0 that cycle, count=0 after, no further writes issued.
